scene_packet_decoder: RTL and testbench
=======================================

# scene_packet_decoder

Decodes 64-bit scene command words delivered by the SPI slave into a double-buffered sphere table for the raytracing controller. Words accumulate in a shadow bank; a FRAME_END command arms a commit that copies shadow to active at the next frame boundary, so the renderer never sees a half-updated scene. It also drives the ready interrupt back to the microcontroller and counts malformed commands. It sits between the SPI slave and the raytracing controller in the CLK100MHZ domain.

## Interface
- NUM_SPHERES, 8, number of sphere slots (1..16)
- ERR_W, 8, width of saturating error counter
- IDX_W, $clog2(NUM_SPHERES) (min 1), derived, not overridden
- CLK100MHZ  in  1  system clock; all logic on rising edge
- ck_rst  in  1  reset, asynchronous assert, active-high
- recv_dv  in  1  one-cycle pulse: recv_64bit holds a complete word
- recv_64bit  in  64  received command word
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- rd_idx  in  IDX_W  active-bank read index
- rd_sphere  out  56  active entry rd_idx: {x[55:44], y[43:32], z[31:20], radius[19:12], color[11:0]}
- sphere_valid  out  NUM_SPHERES  active-bank valid mask
- commit_pending  out  1  FRAME_END received, commit not yet taken
- recv_interrupt  out  1  ready for next scene (to MCU)
- frame_id  out  8  increments on every commit, wraps 255->0
- err_count  out  ERR_W  saturating count of rejected words

## Operation
- Opcode = recv_64bit[63:60], decoded only when recv_dv=1:
  - 0x0 NOP: ignored, no error.
  - 0x1 SPHERE: idx=[59:56]; if idx < NUM_SPHERES, shadow[idx] <= [55:0], shadow_valid[idx] <= 1; else err.
  - 0x2 FRAME_END: commit_pending <= 1 (no effect if already 1).
  - 0x3 CLEAR: shadow_valid <= 0; shadow data retained.
  - 0x4..0xF: err.
- err: err_count <= err_count+1, holds at all-ones.
- Commit FSM: COLLECT (commit_pending=0) -> PENDING on FRAME_END; PENDING -> COLLECT on frame_start. On that edge: active <= shadow, sphere_valid <= shadow_valid, frame_id+1, recv_interrupt <= 1.
- Shadow is not cleared by commit; MCU sends only changed spheres per frame.
- recv_interrupt cleared on any recv_dv (any opcode, including rejected).
- rd_sphere is a combinational mux of active bank by rd_idx; rd_idx >= NUM_SPHERES returns 0.
- Coordinates/radius/color are opaque bit fields; no arithmetic applied.

## Timing
- Reset (async, ck_rst=1): shadow/active data 0, shadow_valid 0, sphere_valid 0, commit_pending 0, frame_id 0, err_count 0, recv_interrupt 1 (ready for first scene). FSM COLLECT.
- Decode latency: effects of word at edge N visible after edge N (registered, 1 cycle).
- Commit latency: sphere_valid/rd_sphere/frame_id update on the frame_start edge; visible next cycle.
- Simultaneous recv_dv SPHERE/CLEAR + frame_start in PENDING: commit copies pre-write shadow; write lands only in shadow.
- Simultaneous FRAME_END + frame_start in COLLECT: commit_pending set, no commit this frame; commits on next frame_start.
- Simultaneous FRAME_END + frame_start in PENDING: commit taken, commit_pending cleared (FRAME_END absorbed into this commit).
- Simultaneous recv_dv + commit: recv_interrupt set wins (ends 1).
- frame_start in COLLECT: no effect.
- Reset mid-PENDING: commit discarded, all state to reset values.
- Back-to-back recv_dv on consecutive cycles supported.

## Test plan
- Reset -> recv_interrupt=1, sphere_valid=0, frame_id=0, err_count=0, rd_sphere=0.
- SPHERE idx 2 data 0x0A0_B0C_0D0_40_F00, FRAME_END, frame_start -> next cycle sphere_valid=0x04, rd_idx=2 gives 0xA0B0C0D040F00, frame_id=1, recv_interrupt=1; before frame_start sphere_valid stays 0 and commit_pending=1.
- Opcode 0x7, then SPHERE idx 9 (NUM_SPHERES=8) -> err_count=2, shadow_valid unchanged; 256 bad words with ERR_W=8 -> err_count=255.
- In PENDING, SPHERE idx 1 on same cycle as frame_start -> sphere_valid bit1 = 0 after commit; next FRAME_END+frame_start -> bit1 = 1.
- CLEAR, FRAME_END, frame_start after a populated commit -> sphere_valid=0, rd_sphere data unchanged, frame_id increments.
- Assert ck_rst while commit_pending=1, release, pulse frame_start -> no commit, frame_id=0, recv_interrupt=1.

Source files
------------

// File: rtl/scene_packet_decoder.sv
// scene_packet_decoder
//
// Decodes 64-bit scene command words from the SPI slave into a double-buffered
// sphere table. SPHERE/CLEAR commands edit a shadow bank; FRAME_END arms a
// commit that copies shadow to active on the next frame_start pulse, so the
// raytracing controller only ever reads a complete scene.
//
// Ports:
//   CLK100MHZ       in   system clock, rising edge
//   ck_rst          in   asynchronous active-high reset
//   recv_dv         in   one-cycle strobe, recv_64bit holds a complete word
//   recv_64bit      in   command word: opcode [63:60], idx [59:56], data [55:0]
//   frame_start     in   one-cycle pulse at start of vertical blanking
//   rd_idx          in   active-bank read index
//   rd_sphere       out  active entry rd_idx {x,y,z,radius,color}, 0 if out of range
//   sphere_valid    out  active-bank valid mask
//   commit_pending  out  FRAME_END seen, commit not yet taken
//   recv_interrupt  out  ready for next scene (to MCU)
//   frame_id        out  commit counter, wraps 255->0
//   err_count       out  saturating count of rejected words
module scene_packet_decoder #(
  parameter int NUM_SPHERES = 8,
  parameter int ERR_W       = 8,
  localparam int IDX_W      = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
  input  logic                   CLK100MHZ,
  input  logic                   ck_rst,
  input  logic                   recv_dv,
  input  logic [63:0]            recv_64bit,
  input  logic                   frame_start,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [55:0]            rd_sphere,
  output logic [NUM_SPHERES-1:0] sphere_valid,
  output logic                   commit_pending,
  output logic                   recv_interrupt,
  output logic [7:0]             frame_id,
  output logic [ERR_W-1:0]       err_count
);

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_SPHERE    = 4'h1;
  localparam logic [3:0] OP_FRAME_END = 4'h2;
  localparam logic [3:0] OP_CLEAR     = 4'h3;

  typedef enum logic {
    ST_COLLECT,
    ST_PENDING
  } state_t;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [55:0]            r_shadow [NUM_SPHERES];
  logic [NUM_SPHERES-1:0] r_shadow_valid;
  logic [55:0]            r_active [NUM_SPHERES];
  logic [NUM_SPHERES-1:0] r_active_valid;
  logic [7:0]             r_frame_id;
  logic [ERR_W-1:0]       r_err_count;
  logic                   r_irq;

  logic [3:0]  w_op;
  logic [3:0]  w_idx;
  logic [55:0] w_data;
  logic        w_idx_ok;
  logic        w_sphere_wr;
  logic        w_clear;
  logic        w_frame_end;
  logic        w_err;
  logic        w_commit;

  // Command decode
  assign w_op        = recv_64bit[63:60];
  assign w_idx       = recv_64bit[59:56];
  assign w_data      = recv_64bit[55:0];
  assign w_idx_ok    = ({28'd0, w_idx} < 32'(NUM_SPHERES));
  assign w_sphere_wr = recv_dv && (w_op == OP_SPHERE) && w_idx_ok;
  assign w_clear     = recv_dv && (w_op == OP_CLEAR);
  assign w_frame_end = recv_dv && (w_op == OP_FRAME_END);
  assign w_err       = recv_dv && (w_op != OP_NOP) && (w_op != OP_FRAME_END) &&
                       (w_op != OP_CLEAR) && !w_sphere_wr;

  // A FRAME_END arriving on the committing edge is absorbed into that commit.
  assign w_commit    = (r_state == ST_PENDING) && frame_start;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: if (w_frame_end) w_state_nxt = ST_PENDING;
      ST_PENDING: if (frame_start) w_state_nxt = ST_COLLECT;
      default:    w_state_nxt = ST_COLLECT;
    endcase
  end

  // Control state
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      r_state     <= ST_COLLECT;
      r_frame_id  <= 8'd0;
      r_err_count <= '0;
      r_irq       <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_commit) r_frame_id <= r_frame_id + 8'd1;
      if (w_err)    r_err_count <= sat_inc(r_err_count);
      // Commit sets the interrupt even if a word is received on the same edge.
      if (w_commit)     r_irq <= 1'b1;
      else if (recv_dv) r_irq <= 1'b0;
    end
  end

  // Shadow bank: written by SPHERE/CLEAR, never touched by commit
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      r_shadow_valid <= '0;
      for (int i = 0; i < NUM_SPHERES; i++) r_shadow[i] <= '0;
    end else begin
      if (w_clear) r_shadow_valid <= '0;
      for (int i = 0; i < NUM_SPHERES; i++) begin
        if (w_sphere_wr && (w_idx == 4'(i))) begin
          r_shadow[i]       <= w_data;
          r_shadow_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Active bank: copies the pre-write shadow contents on the commit edge
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      r_active_valid <= '0;
      for (int i = 0; i < NUM_SPHERES; i++) r_active[i] <= '0;
    end else if (w_commit) begin
      r_active_valid <= r_shadow_valid;
      for (int i = 0; i < NUM_SPHERES; i++) r_active[i] <= r_shadow[i];
    end
  end

  // Read mux; indices with no matching slot fall through to zero
  always_comb begin
    rd_sphere = '0;
    for (int i = 0; i < NUM_SPHERES; i++) begin
      if ({{(32-IDX_W){1'b0}}, rd_idx} == 32'(i)) rd_sphere = r_active[i];
    end
  end

  assign sphere_valid   = r_active_valid;
  assign commit_pending = (r_state == ST_PENDING);
  assign recv_interrupt = r_irq;
  assign frame_id       = r_frame_id;
  assign err_count      = r_err_count;

endmodule

// File: tb/tb_scene_packet_decoder.sv
// Testbench for scene_packet_decoder: a behavioural model predicts the outputs
// after every clock; predictions are queued on the driving edge and compared
// against the DUT shortly after that edge.
module tb_scene_packet_decoder;

  localparam int NS    = 8;
  localparam int ERR_W = 8;
  localparam int IDX_W = 3;

  logic              clk = 1'b0;
  logic              ck_rst;
  logic              recv_dv;
  logic [63:0]       recv_64bit;
  logic              frame_start;
  logic [IDX_W-1:0]  rd_idx;
  logic [55:0]       rd_sphere;
  logic [NS-1:0]     sphere_valid;
  logic              commit_pending;
  logic              recv_interrupt;
  logic [7:0]        frame_id;
  logic [ERR_W-1:0]  err_count;

  scene_packet_decoder #(.NUM_SPHERES(NS), .ERR_W(ERR_W)) dut (
    .CLK100MHZ      (clk),
    .ck_rst         (ck_rst),
    .recv_dv        (recv_dv),
    .recv_64bit     (recv_64bit),
    .frame_start    (frame_start),
    .rd_idx         (rd_idx),
    .rd_sphere      (rd_sphere),
    .sphere_valid   (sphere_valid),
    .commit_pending (commit_pending),
    .recv_interrupt (recv_interrupt),
    .frame_id       (frame_id),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [55:0]   sph;
    logic [NS-1:0] vmask;
    logic          pend;
    logic          irq;
    logic [7:0]    fid;
    logic [7:0]    err;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [55:0]   m_shadow [NS];
  logic [NS-1:0] m_svalid;
  logic [55:0]   m_active [NS];
  logic [NS-1:0] m_valid;
  logic          m_pend;
  logic          m_irq;
  logic [7:0]    m_fid;
  logic [7:0]    m_err;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_svalid = '0; m_valid = '0; m_pend = 1'b0;
    m_irq = 1'b1; m_fid = 8'd0; m_err = 8'd0;
  endtask

  task automatic model_clock(input logic dv, input logic [63:0] w, input logic fs);
    logic [3:0] op;
    logic [3:0] idx;
    logic       commit;
    op     = w[63:60];
    idx    = w[59:56];
    commit = m_pend && fs;
    if (commit) begin
      for (int i = 0; i < NS; i++) m_active[i] = m_shadow[i];
      m_valid = m_svalid;
      m_fid   = m_fid + 8'd1;
      m_pend  = 1'b0;
      m_irq   = 1'b1;
    end else if (dv) begin
      m_irq = 1'b0;
    end
    if (dv) begin
      case (op)
        4'h0: ;
        4'h1: if (idx < NS) begin
                m_shadow[idx] = w[55:0];
                m_svalid[idx] = 1'b1;
              end else if (m_err != 8'hFF) m_err = m_err + 8'd1;
        4'h2: if (!commit) m_pend = 1'b1;
        4'h3: m_svalid = '0;
        default: if (m_err != 8'hFF) m_err = m_err + 8'd1;
      endcase
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check_val("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check_val("commit_pending", {63'd0, commit_pending}, {63'd0, e.pend});
    check_val("recv_interrupt", {63'd0, recv_interrupt}, {63'd0, e.irq});
    check_val("frame_id",       {56'd0, frame_id},       {56'd0, e.fid});
    check_val("err_count",      {56'd0, err_count},      {56'd0, e.err});
    check_val("sphere_valid",   {56'd0, sphere_valid},   {56'd0, e.vmask});
    check_val("rd_sphere",      {8'd0, rd_sphere},       {8'd0, e.sph});
  endtask

  task automatic step(input logic dv, input logic [63:0] w, input logic fs);
    exp_t e;
    @(negedge clk);
    recv_dv = dv; recv_64bit = w; frame_start = fs;
    @(posedge clk);
    model_clock(dv, w, fs);
    e.sph = m_active[rd_idx]; e.vmask = m_valid; e.pend = m_pend;
    e.irq = m_irq; e.fid = m_fid; e.err = m_err;
    sb.push_back(e);
    #1;
    recv_dv = 1'b0; frame_start = 1'b0;
    compare_out();
  endtask

  function automatic logic [63:0] w_sphere(input logic [3:0] idx, input logic [55:0] d);
    return {4'h1, idx, d};
  endfunction

  localparam logic [63:0] W_FEND  = {4'h2, 60'd0};
  localparam logic [63:0] W_CLEAR = {4'h3, 60'd0};
  localparam logic [63:0] W_BAD   = {4'h7, 60'h123};
  localparam logic [63:0] W_NOP   = 64'd0;
  localparam logic [55:0] D_A     = 56'h0A0B0C0D040F00;
  localparam logic [55:0] D_B     = 56'h11122233344555;

  initial begin
    ck_rst = 1'b1; recv_dv = 1'b0; recv_64bit = '0; frame_start = 1'b0; rd_idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_irq",   {63'd0, recv_interrupt}, 64'd1);
    check_val("rst_valid", {56'd0, sphere_valid},   64'd0);
    check_val("rst_fid",   {56'd0, frame_id},       64'd0);
    check_val("rst_err",   {56'd0, err_count},      64'd0);
    check_val("rst_sph",   {8'd0, rd_sphere},       64'd0);
    @(negedge clk); ck_rst = 1'b0;

    // Basic populate and commit
    rd_idx = 3'd2;
    step(1'b1, w_sphere(4'd2, D_A), 1'b0);
    step(1'b1, W_FEND, 1'b0);
    step(1'b0, W_NOP, 1'b0);
    check_val("pre_commit_pend",  {63'd0, commit_pending}, 64'd1);
    check_val("pre_commit_valid", {56'd0, sphere_valid},   64'd0);
    step(1'b0, W_NOP, 1'b1);
    check_val("commit_valid", {56'd0, sphere_valid},   64'h04);
    check_val("commit_sph",   {8'd0, rd_sphere},       64'h000A0B0C0D040F00);
    check_val("commit_fid",   {56'd0, frame_id},       64'd1);
    check_val("commit_irq",   {63'd0, recv_interrupt}, 64'd1);

    // frame_start in COLLECT does nothing; NOP is not an error
    step(1'b1, W_NOP, 1'b1);

    // Rejected words and error saturation
    step(1'b1, W_BAD, 1'b0);
    step(1'b1, w_sphere(4'd9, D_B), 1'b0);
    check_val("err_two", {56'd0, err_count}, 64'd2);
    for (int i = 0; i < 256; i++) step(1'b1, W_BAD, 1'b0);
    check_val("err_sat", {56'd0, err_count}, 64'd255);

    // Write on the commit edge lands only in shadow
    rd_idx = 3'd1;
    step(1'b1, W_FEND, 1'b0);
    step(1'b1, w_sphere(4'd1, D_B), 1'b1);
    check_val("race_valid", {56'd0, sphere_valid}, 64'h04);
    step(1'b1, W_FEND, 1'b0);
    step(1'b0, W_NOP, 1'b1);
    check_val("late_valid", {56'd0, sphere_valid}, 64'h06);
    check_val("late_sph",   {8'd0, rd_sphere},     {8'd0, D_B});

    // FRAME_END + frame_start in COLLECT arms only; in PENDING it is absorbed
    step(1'b1, W_FEND, 1'b1);
    step(1'b1, W_FEND, 1'b1);
    check_val("absorb_pend", {63'd0, commit_pending}, 64'd0);

    // CLEAR after a populated commit keeps data, drops valid
    rd_idx = 3'd2;
    step(1'b1, W_CLEAR, 1'b0);
    step(1'b1, W_FEND, 1'b0);
    step(1'b0, W_NOP, 1'b1);
    check_val("clear_valid", {56'd0, sphere_valid}, 64'd0);
    check_val("clear_sph",   {8'd0, rd_sphere},     {8'd0, D_A});

    // Back-to-back words with varying indices
    for (int i = 0; i < 8; i++) step(1'b1, w_sphere(4'(i), 56'($urandom) ^ {48'd0, 8'(i)}), 1'b0);
    step(1'b1, W_FEND, 1'b0);
    step(1'b0, W_NOP, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      step(1'b0, W_NOP, 1'b0);
    end

    // Reset while a commit is pending discards it
    step(1'b1, W_FEND, 1'b0);
    @(negedge clk);
    #2 ck_rst = 1'b1;
    model_reset();
    #1;
    check_val("arst_pend", {63'd0, commit_pending}, 64'd0);
    check_val("arst_fid",  {56'd0, frame_id},       64'd0);
    check_val("arst_irq",  {63'd0, recv_interrupt}, 64'd1);
    @(posedge clk);
    @(negedge clk); ck_rst = 1'b0;
    step(1'b0, W_NOP, 1'b1);
    check_val("post_rst_fid",   {56'd0, frame_id},       64'd0);
    check_val("post_rst_irq",   {63'd0, recv_interrupt}, 64'd1);
    check_val("post_rst_valid", {56'd0, sphere_valid},   64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
